// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the conv_mac_array convolution engine.
//   state_e     controller states (IDLE, RUN, FINAL, OUT)
//   clog2       ceil(log2(v)), usable in constant expressions
//   beats_for   number of LANES-wide beats needed to cover a window
//   sat_signed  clamp a wide signed value to a narrower signed range
//   ELEMS/BEATS window size and beat count for the default geometry
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Working width for the bias-add / ReLU / saturation path. It must be
    // wider than any accumulator the engine is built with.
    localparam int unsigned SAT_W = 128;

    localparam int DEF_D     = 1;
    localparam int DEF_S     = 5;
    localparam int DEF_LANES = 4;

    localparam int unsigned ELEMS = DEF_D * DEF_S * DEF_S;
    localparam int unsigned BEATS = (ELEMS + DEF_LANES - 1) / DEF_LANES;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned beats_for(input int unsigned elems,
                                              input int unsigned lanes);
        return (elems + lanes - 1) / lanes;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv_mac_lane_sum.sv
// conv_mac_lane_sum: combinational LANES-wide multiply and adder tree.
// For beat b, lane k multiplies element b*LANES+k of img and fit (element 0
// in the most-significant slice). Lanes past the end of the window add 0.
//   img, fit  flattened window and filter
//   beat      current beat index
//   sum       sign-extended sum of all lane products
module conv_mac_lane_sum
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_ELEMS    = ELEMS,
    parameter int unsigned LANES      = 4,
    parameter int unsigned BEAT_W     = (clog2(BEATS) > 0) ? clog2(BEATS) : 1,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 6
) (
    input  logic [N_ELEMS*DATA_WIDTH-1:0] img,
    input  logic [N_ELEMS*DATA_WIDTH-1:0] fit,
    input  logic [BEAT_W-1:0]             beat,
    output logic signed [ACC_WIDTH-1:0]   sum
);

    logic signed [DATA_WIDTH-1:0]   a;
    logic signed [DATA_WIDTH-1:0]   b;
    logic signed [2*DATA_WIDTH-1:0] prod;
    int unsigned                    idx;

    always_comb begin
        sum  = '0;
        a    = '0;
        b    = '0;
        prod = '0;
        idx  = 0;
        for (int unsigned k = 0; k < LANES; k++) begin
            idx = 32'(beat) * LANES + k;
            a   = '0;
            b   = '0;
            if (idx < N_ELEMS) begin
                a = img[(N_ELEMS - 1 - idx) * DATA_WIDTH +: DATA_WIDTH];
                b = fit[(N_ELEMS - 1 - idx) * DATA_WIDTH +: DATA_WIDTH];
            end
            prod = a * b;
            sum  = sum + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/conv_mac_array.sv
// conv_mac_array: multi-lane signed dot-product engine for one output pixel
// (D x S x S window times filter, plus bias), with optional ReLU and
// saturation to DATA_WIDTH.
//   clk, rst            clock, asynchronous active-high reset
//   start               request a job (accepted in IDLE, or in OUT with res_ready)
//   img, fit, bias      operands, latched at accept
//   relu_en             clamp negative results to 0, latched at accept
//   busy                high from accept until the result is taken
//   res, res_valid      saturated result and its qualifier
//   res_ready           downstream takes res
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int D          = DEF_D,
    parameter int S          = DEF_S,
    parameter int LANES      = DEF_LANES,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(D * S * S) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [D*S*S*DATA_WIDTH-1:0]  img,
    input  logic [D*S*S*DATA_WIDTH-1:0]  fit,
    input  logic [DATA_WIDTH-1:0]        bias,
    input  logic                         relu_en,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        res,
    output logic                         res_valid,
    input  logic                         res_ready
);

    localparam int unsigned N_ELEMS = D * S * S;
    localparam int unsigned N_BEATS = beats_for(N_ELEMS, LANES);
    localparam int unsigned BEAT_W  = (clog2(N_BEATS) > 0) ? clog2(N_BEATS) : 1;
    localparam int unsigned VEC_W   = N_ELEMS * DATA_WIDTH;

    state_e                       state_q, state_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [VEC_W-1:0]             img_q, img_d;
    logic [VEC_W-1:0]             fit_q, fit_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic                         relu_q, relu_d;
    logic [DATA_WIDTH-1:0]        res_q, res_d;

    logic signed [ACC_WIDTH-1:0]  lane_sum;
    logic signed [SAT_W-1:0]      v;
    logic signed [SAT_W-1:0]      v_sat;
    logic                         accept;

    conv_mac_lane_sum #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_ELEMS    (N_ELEMS),
        .LANES      (LANES),
        .BEAT_W     (BEAT_W),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane_sum (
        .img  (img_q),
        .fit  (fit_q),
        .beat (beat_q),
        .sum  (lane_sum)
    );

    // Bias add, ReLU and clamp, evaluated in a width that cannot overflow.
    always_comb begin
        v = SAT_W'(acc_q) + SAT_W'(bias_q);
        if (relu_q && v[SAT_W-1]) begin
            v = '0;
        end
        v_sat = sat_signed(v, DATA_WIDTH);
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        img_d   = img_q;
        fit_d   = fit_q;
        bias_d  = bias_q;
        relu_d  = relu_q;
        res_d   = res_q;

        accept = start && ((state_q == IDLE) || ((state_q == OUT) && res_ready));

        case (state_q)
            IDLE: ;
            RUN: begin
                acc_d  = acc_q + lane_sum;
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(N_BEATS - 1)) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                res_d   = v_sat[DATA_WIDTH-1:0];
                state_d = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A job accepted from IDLE or straight out of OUT loads identically;
        // this overrides the OUT->IDLE move above.
        if (accept) begin
            img_d   = img;
            fit_d   = fit;
            bias_d  = bias;
            relu_d  = relu_en;
            acc_d   = '0;
            beat_d  = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            acc_q   <= '0;
            img_q   <= '0;
            fit_q   <= '0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            img_q   <= img_d;
            fit_q   <= fit_d;
            bias_q  <= bias_d;
            relu_q  <= relu_d;
            res_q   <= res_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == OUT);
    assign res       = res_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// tb_conv_mac_array: directed bench for conv_mac_array.
// Three instances: A (32-bit, D=1 S=3 LANES=4), B (8-bit, D=1 S=3 LANES=2),
// C (32-bit, D=2 S=3 LANES=4). Expected results are hand-computed constants.
module tb_conv_mac_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A
    logic               a_start = 0, a_relu = 0, a_res_ready = 0;
    logic [9*32-1:0]    a_img = '0, a_fit = '0;
    logic [31:0]        a_bias = '0;
    logic               a_busy, a_res_valid;
    logic signed [31:0] a_res;

    // Instance B
    logic               b_start = 0, b_relu = 0, b_res_ready = 0;
    logic [9*8-1:0]     b_img = '0, b_fit = '0;
    logic [7:0]         b_bias = '0;
    logic               b_busy, b_res_valid;
    logic signed [7:0]  b_res;

    // Instance C
    logic               c_start = 0, c_relu = 0, c_res_ready = 0;
    logic [18*32-1:0]   c_img = '0, c_fit = '0;
    logic [31:0]        c_bias = '0;
    logic               c_busy, c_res_valid;
    logic signed [31:0] c_res;

    conv_mac_array #(.DATA_WIDTH(32), .D(1), .S(3), .LANES(4)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .img(a_img), .fit(a_fit),
        .bias(a_bias), .relu_en(a_relu), .busy(a_busy), .res(a_res),
        .res_valid(a_res_valid), .res_ready(a_res_ready)
    );

    conv_mac_array #(.DATA_WIDTH(8), .D(1), .S(3), .LANES(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .img(b_img), .fit(b_fit),
        .bias(b_bias), .relu_en(b_relu), .busy(b_busy), .res(b_res),
        .res_valid(b_res_valid), .res_ready(b_res_ready)
    );

    conv_mac_array #(.DATA_WIDTH(32), .D(2), .S(3), .LANES(4)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .img(c_img), .fit(c_fit),
        .bias(c_bias), .relu_en(c_relu), .busy(c_busy), .res(c_res),
        .res_valid(c_res_valid), .res_ready(c_res_ready)
    );

    typedef struct {
        logic signed [31:0] iv;
        logic signed [31:0] fv;
        logic signed [31:0] bv;
        logic               relu;
        logic signed [31:0] exp;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl [NV];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic launch_a(input logic signed [31:0] iv, input logic signed [31:0] fv,
                            input logic signed [31:0] bv, input logic rl);
        @(negedge clk);
        a_img = {9{iv}};
        a_fit = {9{fv}};
        a_bias = bv;
        a_relu = rl;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    // Called at the negedge right after the accepting posedge; k counts
    // posedges until res_valid is seen.
    task automatic wait_a(output int k, output bit busy_ok);
        k = 0;
        busy_ok = 1'b1;
        while (!a_res_valid && k < 40) begin
            @(negedge clk);
            k++;
            if (!a_busy) busy_ok = 1'b0;
        end
    endtask

    task automatic handshake_a(input string tag);
        a_res_ready = 1'b1;
        @(negedge clk);
        a_res_ready = 1'b0;
        check({tag, "_valid_clr"}, longint'(a_res_valid), 0);
        check({tag, "_busy_clr"}, longint'(a_busy), 0);
    endtask

    task automatic run_a(input logic signed [31:0] iv, input logic signed [31:0] fv,
                         input logic signed [31:0] bv, input logic rl,
                         input logic signed [31:0] exp, input string tag);
        int k;
        bit bo;
        launch_a(iv, fv, bv, rl);
        check({tag, "_busy_acc"}, longint'(a_busy), 1);
        check({tag, "_valid_acc"}, longint'(a_res_valid), 0);
        wait_a(k, bo);
        check({tag, "_latency"}, k, 4);
        check({tag, "_busy_run"}, longint'(bo), 1);
        check({tag, "_res"}, longint'(a_res), longint'(exp));
        handshake_a(tag);
    endtask

    task automatic run_b(input logic signed [7:0] iv, input logic signed [7:0] fv,
                         input logic signed [7:0] exp, input string tag);
        int k;
        @(negedge clk);
        b_img = {9{iv}};
        b_fit = {9{fv}};
        b_bias = '0;
        b_relu = 1'b0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        k = 0;
        while (!b_res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 6);
        check({tag, "_res"}, longint'(b_res), longint'(exp));
        b_res_ready = 1'b1;
        @(negedge clk);
        b_res_ready = 1'b0;
        check({tag, "_busy_clr"}, longint'(b_busy), 0);
    endtask

    initial begin
        int k;
        bit bo;
        bit stable_ok;

        tbl[0] = '{32'sd1,  32'sd2,  32'sd1,  1'b0, 32'sd19};
        tbl[1] = '{32'sd1,  -32'sd3, 32'sd5,  1'b1, 32'sd0};
        tbl[2] = '{32'sd1,  -32'sd3, 32'sd5,  1'b0, -32'sd22};
        tbl[3] = '{32'sd2,  32'sd3,  -32'sd4, 1'b0, 32'sd50};
        tbl[4] = '{-32'sd1, 32'sd5,  32'sd10, 1'b0, -32'sd35};
        tbl[5] = '{-32'sd1, 32'sd5,  32'sd10, 1'b1, 32'sd0};
        tbl[6] = '{32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sd0, 1'b0, 32'sh7FFFFFFF};
        tbl[7] = '{32'sh80000000, 32'sh7FFFFFFF, 32'sd0, 1'b0, 32'sh80000000};
        tbl[8] = '{32'sh80000000, 32'sh80000000, -32'sd1, 1'b1, 32'sh7FFFFFFF};
        tbl[9] = '{32'sd0,  32'sd0,  -32'sd7, 1'b0, -32'sd7};

        // Reset state
        #2;
        check("rst_a_busy", longint'(a_busy), 0);
        check("rst_a_valid", longint'(a_res_valid), 0);
        check("rst_a_res", longint'(a_res), 0);
        check("rst_b_res", longint'(b_res), 0);
        check("rst_c_busy", longint'(c_busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with start low stays idle
        @(negedge clk);
        check("idle_hold", longint'(a_busy), 0);

        for (int i = 0; i < NV; i++) begin
            run_a(tbl[i].iv, tbl[i].fv, tbl[i].bv, tbl[i].relu, tbl[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Saturation at 8 bits
        run_b(8'sd127, 8'sd127, 8'sd127, "b_satpos");
        run_b(8'sd127, -8'sd128, -8'sd128, "b_satneg");

        // 18 elements over 5 beats, last beat with two lanes masked
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            c_img[(17 - i) * 32 +: 32] = 32'(i);
        end
        c_fit = {18{32'sd1}};
        c_bias = '0;
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        k = 0;
        while (!c_res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("c_latency", k, 6);
        check("c_res", longint'(c_res), 153);
        c_res_ready = 1'b1;
        @(negedge clk);
        c_res_ready = 1'b0;
        check("c_busy_clr", longint'(c_busy), 0);

        // Backpressure: result held, start ignored while res_ready is low
        launch_a(32'sd1, 32'sd2, 32'sd1, 1'b0);
        wait_a(k, bo);
        check("bp_latency", k, 4);
        check("bp_res", longint'(a_res), 19);
        stable_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a_start = c[0];
            a_img = c[0] ? {9{32'sd9}} : '0;
            @(negedge clk);
            if (a_res !== 32'sd19 || !a_res_valid || !a_busy) stable_ok = 1'b0;
        end
        check("bp_stable", longint'(stable_ok), 1);
        // Take the result and start a new job in the same cycle
        a_img = {9{32'sd1}};
        a_fit = {9{32'sd1}};
        a_bias = '0;
        a_relu = 1'b0;
        a_start = 1'b1;
        a_res_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_res_ready = 1'b0;
        check("b2b_valid_clr", longint'(a_res_valid), 0);
        check("b2b_busy", longint'(a_busy), 1);
        check("b2b_res_kept", longint'(a_res), 19);
        wait_a(k, bo);
        check("b2b_latency", k, 4);
        check("b2b_busy_run", longint'(bo), 1);
        check("b2b_res", longint'(a_res), 9);
        handshake_a("b2b");

        // Asynchronous reset during beat 1
        launch_a(32'sd1, 32'sd2, 32'sd1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", longint'(a_busy), 0);
        check("arst_valid", longint'(a_res_valid), 0);
        check("arst_res", longint'(a_res), 0);
        @(negedge clk);
        rst = 1'b0;
        run_a(32'sd1, -32'sd3, 32'sd5, 1'b0, -32'sd22, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_mac_array.md
Name: conv_mac_array

Overview:
- Multi-lane signed-integer convolution engine. Computes one output pixel as the dot product of a D×S×S image window and filter, plus a bias.
- Adds lane parallelism, a start/busy/valid-ready handshake, a wide accumulator, run-time ReLU and output saturation.
- Sits between the window/line-buffer stage (upstream) and the feature-map writer (downstream).

Parameters:
- DATA_WIDTH, 32: width of each signed two's-complement element of img, fit, bias and res.
- D, 1: filter depth (channels).
- S, 5: filter side length.
- LANES, 4: multipliers used per cycle; 1 ≤ LANES ≤ D*S*S.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(D*S*S)+1: signed accumulator width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new convolution; sampled only when it can be accepted (see Behaviour).
- img  in  D*S*S*DATA_WIDTH  image window, element 0 in the most-significant slice.
- fit  in  D*S*S*DATA_WIDTH  filter weights, same packing as img.
- bias  in  DATA_WIDTH  signed bias.
- relu_en  in  1  apply ReLU to this result; captured at accept.
- busy  out  1  high from accept until the result is taken.
- res  out  DATA_WIDTH  saturated signed result.
- res_valid  out  1  res holds a valid result.
- res_ready  in  1  downstream accepts res.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, res=0, res_valid=0, beat counter=0, acc=0, operand registers=0.
- Constant N = ceil(D*S*S/LANES) beats.
- IDLE:
  - start=1 at an edge: latch img, fit, bias and relu_en; acc=0; beat=0; busy=1; go to RUN.
  - start=0: stay in IDLE.
- RUN, beat b:
  - Lane k multiplies element b*LANES+k of the latched img and fit. Each product is full 2*DATA_WIDTH signed, then sign-extended.
  - Lanes whose index is ≥ D*S*S in the last beat contribute 0.
  - acc += sum of all lane products; b increments.
  - After beat N-1: go to FINAL.
- FINAL (one cycle):
  - v = acc + sign-extended bias.
  - If relu_en and v<0, then v=0.
  - res = v clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; res_valid=1; go to OUT.
- OUT:
  - res and res_valid are held stable while res_ready=0.
  - res_ready=1 and start=0: res_valid=0, busy=0, go to IDLE.
  - res_ready=1 and start=1 in the same cycle: accept the new job directly. Latch the operands, res_valid=0, busy stays 1, go to RUN.
- Latency: accept edge to res_valid rising = N+1 cycles. Back-to-back throughput is one result per N+2 cycles.
- Any other state: start is ignored, and input changes do not affect the job in flight, because operands are latched at accept.
- res keeps its last value after the handshake; only res_valid qualifies it.
- Overflow: ACC_WIDTH guarantees no accumulator overflow for the defaults. If the parameter is overridden smaller, wrap-around is permitted.

Decomposition:
- Package conv_pkg holds:
  - state enum IDLE/RUN/FINAL/OUT;
  - function clog2;
  - function sat_signed(value, width);
  - derived constants ELEMS=D*S*S and BEATS=N.
- One sub-module, conv_mac_lane_sum: combinational LANES-wide multiply-and-adder-tree with zero masking of out-of-range lanes. The top level holds the FSM, the counter, the accumulator and the output register.

Test Plan:
- D=1, S=3, LANES=4 (N=3); img all 1, fit all 2, bias=1, relu_en=0; pulse start → res_valid rises 4 cycles after accept, res=19, busy high throughout.
- Same config, img all 1, fit all -3, bias=5, relu_en=1 → res=0. Repeat with relu_en=0 → res=-22.
- DATA_WIDTH=8, D=1, S=3, LANES=2; img all 127, fit all 127, bias=0 → res=127 (saturated). With fit all -128 → res=-128.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid rises, toggling start and img → res stable, no new job accepted. Then res_ready=1 with start=1 → the new job is accepted and its result appears N+1 cycles later.
- Assert rst mid-RUN at beat 1 → busy, res_valid and res go to 0 immediately (asynchronously). A fresh start afterwards gives a correct result with no carry-over from the aborted accumulation.
- D=2, S=3, LANES=4 (18 elements, last beat 2 lanes masked); img element i=i, fit all 1, bias=0 → res=153.
